// File: rtl/microondas_pkg.sv
// Shared types for the programmable microwave controller: state and step
// encodings, the mm:ss time record and conversions between mm:ss and seconds.
package microondas_pkg;

  localparam int MAX_STAGES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    STEP_1S  = 2'b00,
    STEP_10S = 2'b01,
    STEP_1M  = 2'b10,
    STEP_10M = 2'b11
  } step_e;

  typedef struct packed {
    logic [6:0] mins;
    logic [5:0] secs;
  } mmss_t;

  function automatic logic [12:0] step_secs(input step_e s);
    case (s)
      STEP_1S:  return 13'd1;
      STEP_10S: return 13'd10;
      STEP_1M:  return 13'd60;
      default:  return 13'd600;
    endcase
  endfunction

  function automatic logic [12:0] to_secs(input mmss_t t);
    return 13'(t.mins) * 13'd60 + 13'(t.secs);
  endfunction

  function automatic mmss_t from_secs(input logic [12:0] s);
    mmss_t r;
    r.mins = 7'(s / 13'd60);
    r.secs = 6'(s % 13'd60);
    return r;
  endfunction

  function automatic logic is_zero(input mmss_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/ctrl_microondas_prog_if.sv
// Front-panel bundle of the microwave controller: raw buttons and levels in,
// display and heater drive out.
interface ctrl_microondas_prog_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic       mais;
  logic       menos;
  logic       porta;
  logic       sel_pot;
  logic [1:0] step_mode;
  logic [1:0] stage_sel;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic [1:0] stage_out;
  logic [2:0] pot_out;
  logic [1:0] estado;
  logic       magnetron;
  logic       done;

  modport master (
    output start, stop, pause, mais, menos, porta, sel_pot, step_mode, stage_sel,
    input  min_out, sec_out, stage_out, pot_out, estado, magnetron, done
  );

  modport slave (
    input  start, stop, pause, mais, menos, porta, sel_pot, step_mode, stage_sel,
    output min_out, sec_out, stage_out, pot_out, estado, magnetron, done
  );
endinterface

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle registered pulse, one cycle after the input rises.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);
  logic prev_q;
  logic pulse_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= btn_i;
      pulse_q <= btn_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/ctrl_microondas_prog.sv
// Programmable multi-stage microwave controller: stage editing in IDLE,
// per-second countdown with stage chaining, door/pause handling and power duty cycle.
module ctrl_microondas_prog
  import microondas_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int NUM_POT    = 5,
  parameter int MAX_MIN    = 99,
  parameter int TICK_DIV   = 100_000_000,
  parameter int BEEP_SEC   = 3
) (
  input logic                  clock,
  input logic                  reset,
  ctrl_microondas_prog_if.slave bus
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int              BW         = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0]   BEEP_LAST  = BW'(BEEP_SEC - 1);
  localparam logic [2:0]      POT_MAX    = 3'(NUM_POT - 1);
  localparam logic [12:0]     T_MAX      = 13'(MAX_MIN * 60 + 59);

  logic start_p, stop_p, pause_p, mais_p, menos_p;

  edge_detector u_ed_start (.clock(clock), .reset(reset), .btn_i(bus.start), .pulse_o(start_p));
  edge_detector u_ed_stop  (.clock(clock), .reset(reset), .btn_i(bus.stop),  .pulse_o(stop_p));
  edge_detector u_ed_pause (.clock(clock), .reset(reset), .btn_i(bus.pause), .pulse_o(pause_p));
  edge_detector u_ed_mais  (.clock(clock), .reset(reset), .btn_i(bus.mais),  .pulse_o(mais_p));
  edge_detector u_ed_menos (.clock(clock), .reset(reset), .btn_i(bus.menos), .pulse_o(menos_p));

  state_e        state_q, state_d;
  logic [1:0]    stage_q, stage_d;
  logic [1:0]    edit_q, edit_d;
  mmss_t         work_q, work_d;
  mmss_t         prog_q [MAX_STAGES];
  mmss_t         prog_d [MAX_STAGES];
  logic [2:0]    pot_q  [MAX_STAGES];
  logic [2:0]    pot_d  [MAX_STAGES];
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    duty_q, duty_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          mag_q, mag_d;

  logic          tick;
  logic          any_nz;
  logic [1:0]    first_nz;
  logic          has_next;
  logic [1:0]    next_nz;
  logic [12:0]   t_cur, t_step, t_adj;
  mmss_t         work_dec;

  assign tick = (presc_q == PRESC_LAST);

  // Lowest programmed stage overall and lowest one after the active stage.
  always_comb begin
    any_nz   = 1'b0;
    first_nz = 2'd0;
    has_next = 1'b0;
    next_nz  = 2'd0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (i < NUM_STAGES && !is_zero(prog_q[i])) begin
        any_nz   = 1'b1;
        first_nz = 2'(i);
        if (i > int'(stage_q)) begin
          has_next = 1'b1;
          next_nz  = 2'(i);
        end
      end
    end
  end

  always_comb begin
    t_cur  = to_secs(prog_q[edit_q]);
    t_step = step_secs(step_e'(bus.step_mode));
    if (mais_p) t_adj = (t_cur + t_step > T_MAX) ? T_MAX : t_cur + t_step;
    else        t_adj = (t_cur < t_step) ? 13'd0 : t_cur - t_step;

    work_dec = work_q;
    if (work_q.secs != 6'd0) begin
      work_dec.secs = work_q.secs - 6'd1;
    end else if (work_q.mins != 7'd0) begin
      work_dec.mins = work_q.mins - 7'd1;
      work_dec.secs = 6'd59;
    end
  end

  // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    edit_d  = edit_q;
    work_d  = work_q;
    prog_d  = prog_q;
    pot_d   = pot_q;
    presc_d = presc_q;
    duty_d  = duty_q;
    beep_d  = beep_q;

    unique case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        duty_d  = '0;
        beep_d  = '0;
        if (int'(bus.stage_sel) < NUM_STAGES) edit_d = bus.stage_sel;
        if (stop_p) begin
          for (int i = 0; i < MAX_STAGES; i++) begin
            prog_d[i] = '0;
            pot_d[i]  = POT_MAX;
          end
        end else if (start_p && !bus.porta && any_nz) begin
          state_d = ST_RUN;
          stage_d = first_nz;
          work_d  = prog_q[first_nz];
        end else if (mais_p ^ menos_p) begin
          if (bus.sel_pot) begin
            if (mais_p && pot_q[edit_q] != POT_MAX)      pot_d[edit_q] = pot_q[edit_q] + 3'd1;
            else if (menos_p && pot_q[edit_q] != 3'd0)   pot_d[edit_q] = pot_q[edit_q] - 3'd1;
          end else begin
            prog_d[edit_q] = from_secs(t_adj);
          end
        end
      end

      ST_RUN: begin
        if (stop_p) begin
          state_d = ST_IDLE;
        end else if (pause_p || bus.porta) begin
          state_d = ST_PAUSED;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            duty_d = (duty_q == POT_MAX) ? 3'd0 : duty_q + 3'd1;
            work_d = work_dec;
            // A stage hitting 0:00 hands over in the same cycle.
            if (is_zero(work_dec)) begin
              if (has_next) begin
                stage_d = next_nz;
                work_d  = prog_q[next_nz];
              end else begin
                state_d = ST_DONE;
                beep_d  = '0;
              end
            end
          end
        end
      end

      ST_PAUSED: begin
        if (stop_p)                                    state_d = ST_IDLE;
        else if ((start_p || pause_p) && !bus.porta)   state_d = ST_RUN;
      end

      ST_DONE: begin
        if (stop_p) begin
          state_d = ST_IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (beep_q == BEEP_LAST) state_d = ST_IDLE;
            else                     beep_d  = beep_q + BW'(1);
          end
        end
      end
    endcase

    mag_d = (state_d == ST_RUN) && (duty_d <= pot_q[stage_d]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stage_q <= 2'd0;
      edit_q  <= 2'd0;
      work_q  <= '0;
      presc_q <= '0;
      duty_q  <= '0;
      beep_q  <= '0;
      mag_q   <= 1'b0;
      // NOTE: the stage program is a small register file that must come up cleared, so it is reset like any other state.
      for (int i = 0; i < MAX_STAGES; i++) begin
        prog_q[i] <= '0;
        pot_q[i]  <= POT_MAX;
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      edit_q  <= edit_d;
      work_q  <= work_d;
      presc_q <= presc_d;
      duty_q  <= duty_d;
      beep_q  <= beep_d;
      mag_q   <= mag_d;
      prog_q  <= prog_d;
      pot_q   <= pot_d;
    end
  end

  logic [1:0] disp_stage;
  assign disp_stage    = (state_q == ST_IDLE) ? edit_q : stage_q;
  assign bus.stage_out = disp_stage;
  assign bus.min_out   = (state_q == ST_IDLE) ? prog_q[edit_q].mins : work_q.mins;
  assign bus.sec_out   = (state_q == ST_IDLE) ? prog_q[edit_q].secs : work_q.secs;
  assign bus.pot_out   = pot_q[disp_stage];
  assign bus.estado    = state_q;
  assign bus.done      = (state_q == ST_DONE);
  // Door opening cuts the heater without waiting for the state change.
  assign bus.magnetron = mag_q & ~bus.porta;

endmodule

// File: tb/tb_ctrl_microondas_prog.sv
// Directed bench for ctrl_microondas_prog with TICK_DIV=4, NUM_POT=5, NUM_STAGES=2, BEEP_SEC=3.
module tb_ctrl_microondas_prog;

  localparam logic [4:0] B_START = 5'b00001;
  localparam logic [4:0] B_STOP  = 5'b00010;
  localparam logic [4:0] B_PAUSE = 5'b00100;
  localparam logic [4:0] B_MAIS  = 5'b01000;
  localparam logic [4:0] B_MENOS = 5'b10000;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ctrl_microondas_prog_if bus ();

  ctrl_microondas_prog #(
    .NUM_STAGES(2), .NUM_POT(5), .MAX_MIN(99), .TICK_DIV(4), .BEEP_SEC(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Button pulse is acted on by the FSM at the second rising edge; returns on the negedge after it.
  task automatic press(input logic [4:0] m);
    @(negedge clock);
    {bus.menos, bus.mais, bus.pause, bus.stop, bus.start} = m;
    @(negedge clock);
    {bus.menos, bus.mais, bus.pause, bus.stop, bus.start} = 5'b0;
    @(negedge clock);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    {bus.menos, bus.mais, bus.pause, bus.stop, bus.start} = 5'b0;
    bus.porta = 1'b0; bus.sel_pot = 1'b0; bus.step_mode = 2'd0; bus.stage_sel = 2'd0;
    #12;
    checks++; if (bus.estado !== 2'd0) begin errors++; $display("FAIL reset_estado got %0d exp 0", bus.estado); end
    checks++; if (bus.min_out !== 7'd0 || bus.sec_out !== 6'd0) begin errors++; $display("FAIL reset_time got %0d:%0d exp 0:0", bus.min_out, bus.sec_out); end
    checks++; if (bus.stage_out !== 2'd0) begin errors++; $display("FAIL reset_stage got %0d exp 0", bus.stage_out); end
    checks++; if (bus.pot_out !== 3'd4) begin errors++; $display("FAIL reset_pot got %0d exp 4", bus.pot_out); end
    checks++; if (bus.magnetron !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_mag_done got %0b%0b exp 00", bus.magnetron, bus.done); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_start_blocked;
    press(B_START);
    checks++; if (bus.estado !== 2'd0) begin errors++; $display("FAIL start_empty estado got %0d exp 0", bus.estado); end
    bus.stage_sel = 2'd1;
    repeat (2) press(B_MAIS);
    bus.stage_sel = 2'd0;
    bus.porta = 1'b1;
    press(B_START);
    checks++; if (bus.estado !== 2'd0) begin errors++; $display("FAIL start_door estado got %0d exp 0", bus.estado); end
    bus.porta = 1'b0;
    press(B_START);
    checks++; if (bus.estado !== 2'd1 || bus.stage_out !== 2'd1 || bus.sec_out !== 6'd2) begin errors++; $display("FAIL start_first_nz got st%0d stg%0d s%0d exp st1 stg1 s2", bus.estado, bus.stage_out, bus.sec_out); end
    press(B_STOP);
  endtask

  task automatic test_program_and_run;
    press(B_STOP);
    bus.stage_sel = 2'd0; bus.sel_pot = 1'b0; bus.step_mode = 2'd0;
    repeat (3) press(B_MAIS);
    checks++; if (bus.min_out !== 7'd0 || bus.sec_out !== 6'd3) begin errors++; $display("FAIL prog_s0 got %0d:%0d exp 0:3", bus.min_out, bus.sec_out); end
    bus.stage_sel = 2'd1;
    repeat (2) press(B_MAIS);
    checks++; if (bus.stage_out !== 2'd1 || bus.sec_out !== 6'd2) begin errors++; $display("FAIL prog_s1 got stg%0d s%0d exp stg1 s2", bus.stage_out, bus.sec_out); end
    bus.sel_pot = 1'b1;
    repeat (5) press(B_MENOS);
    checks++; if (bus.pot_out !== 3'd0) begin errors++; $display("FAIL pot_floor got %0d exp 0", bus.pot_out); end
    bus.sel_pot = 1'b0; bus.stage_sel = 2'd0;
    press(B_START);
    checks++; if (bus.estado !== 2'd1 || bus.stage_out !== 2'd0 || bus.sec_out !== 6'd3) begin errors++; $display("FAIL run_entry got st%0d stg%0d s%0d exp st1 stg0 s3", bus.estado, bus.stage_out, bus.sec_out); end
    checks++; if (bus.pot_out !== 3'd4 || bus.magnetron !== 1'b1) begin errors++; $display("FAIL run_entry_pot got p%0d m%0b exp p4 m1", bus.pot_out, bus.magnetron); end
    wait_cyc(11);
    checks++; if (bus.stage_out !== 2'd0 || bus.sec_out !== 6'd1 || bus.magnetron !== 1'b1) begin errors++; $display("FAIL stage0_end got stg%0d s%0d m%0b exp stg0 s1 m1", bus.stage_out, bus.sec_out, bus.magnetron); end
    wait_cyc(1);
    checks++; if (bus.stage_out !== 2'd1 || bus.sec_out !== 6'd2 || bus.estado !== 2'd1) begin errors++; $display("FAIL stage1_start got stg%0d s%0d st%0d exp stg1 s2 st1", bus.stage_out, bus.sec_out, bus.estado); end
    checks++; if (bus.pot_out !== 3'd0 || bus.magnetron !== 1'b0) begin errors++; $display("FAIL stage1_pot got p%0d m%0b exp p0 m0", bus.pot_out, bus.magnetron); end
    wait_cyc(7);
    checks++; if (bus.estado !== 2'd1 || bus.sec_out !== 6'd1) begin errors++; $display("FAIL stage1_end got st%0d s%0d exp st1 s1", bus.estado, bus.sec_out); end
    wait_cyc(1);
    checks++; if (bus.estado !== 2'd3 || bus.done !== 1'b1 || bus.magnetron !== 1'b0) begin errors++; $display("FAIL done_entry got st%0d d%0b m%0b exp st3 d1 m0", bus.estado, bus.done, bus.magnetron); end
    wait_cyc(11);
    checks++; if (bus.estado !== 2'd3 || bus.done !== 1'b1) begin errors++; $display("FAIL done_hold got st%0d d%0b exp st3 d1", bus.estado, bus.done); end
    wait_cyc(1);
    checks++; if (bus.estado !== 2'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL done_exit got st%0d d%0b exp st0 d0", bus.estado, bus.done); end
    checks++; if (bus.sec_out !== 6'd3 || bus.stage_out !== 2'd0) begin errors++; $display("FAIL retain_s0 got stg%0d s%0d exp stg0 s3", bus.stage_out, bus.sec_out); end
    bus.stage_sel = 2'd1;
    wait_cyc(1);
    checks++; if (bus.sec_out !== 6'd2 || bus.pot_out !== 3'd0) begin errors++; $display("FAIL retain_s1 got s%0d p%0d exp s2 p0", bus.sec_out, bus.pot_out); end
    bus.stage_sel = 2'd0;
  endtask

  task automatic test_time_limits;
    press(B_STOP);
    bus.step_mode = 2'd3;
    repeat (10) press(B_MAIS);
    checks++; if (bus.min_out !== 7'd99 || bus.sec_out !== 6'd59) begin errors++; $display("FAIL sat_top got %0d:%0d exp 99:59", bus.min_out, bus.sec_out); end
    bus.step_mode = 2'd0;
    repeat (4) press(B_MENOS);
    checks++; if (bus.min_out !== 7'd99 || bus.sec_out !== 6'd55) begin errors++; $display("FAIL at_9955 got %0d:%0d exp 99:55", bus.min_out, bus.sec_out); end
    bus.step_mode = 2'd1;
    press(B_MAIS);
    checks++; if (bus.min_out !== 7'd99 || bus.sec_out !== 6'd59) begin errors++; $display("FAIL sat_10s got %0d:%0d exp 99:59", bus.min_out, bus.sec_out); end
    press(B_STOP);
    checks++; if (bus.min_out !== 7'd0 || bus.sec_out !== 6'd0 || bus.pot_out !== 3'd4) begin errors++; $display("FAIL stop_clear got %0d:%0d p%0d exp 0:0 p4", bus.min_out, bus.sec_out, bus.pot_out); end
    bus.step_mode = 2'd0;
    repeat (5) press(B_MAIS);
    bus.step_mode = 2'd1;
    press(B_MENOS);
    checks++; if (bus.min_out !== 7'd0 || bus.sec_out !== 6'd0) begin errors++; $display("FAIL sat_zero got %0d:%0d exp 0:0", bus.min_out, bus.sec_out); end
    repeat (6) press(B_MAIS);
    checks++; if (bus.min_out !== 7'd1 || bus.sec_out !== 6'd0) begin errors++; $display("FAIL carry got %0d:%0d exp 1:0", bus.min_out, bus.sec_out); end
    bus.step_mode = 2'd0;
    press(B_MENOS);
    checks++; if (bus.min_out !== 7'd0 || bus.sec_out !== 6'd59) begin errors++; $display("FAIL borrow got %0d:%0d exp 0:59", bus.min_out, bus.sec_out); end
    press(B_MAIS | B_MENOS);
    checks++; if (bus.min_out !== 7'd0 || bus.sec_out !== 6'd59) begin errors++; $display("FAIL both_time got %0d:%0d exp 0:59", bus.min_out, bus.sec_out); end
    bus.sel_pot = 1'b1;
    press(B_MAIS);
    checks++; if (bus.pot_out !== 3'd4) begin errors++; $display("FAIL pot_ceiling got %0d exp 4", bus.pot_out); end
    press(B_MENOS);
    press(B_MAIS | B_MENOS);
    checks++; if (bus.pot_out !== 3'd3) begin errors++; $display("FAIL both_pot got %0d exp 3", bus.pot_out); end
    bus.sel_pot = 1'b0;
    bus.stage_sel = 2'd2;
    wait_cyc(2);
    checks++; if (bus.stage_out !== 2'd0) begin errors++; $display("FAIL stage_sel_range got %0d exp 0", bus.stage_out); end
    bus.stage_sel = 2'd0;
  endtask

  task automatic test_done_stop;
    press(B_STOP);
    bus.step_mode = 2'd0;
    press(B_MAIS);
    press(B_START);
    wait_cyc(4);
    checks++; if (bus.estado !== 2'd3 || bus.done !== 1'b1) begin errors++; $display("FAIL short_done got st%0d d%0b exp st3 d1", bus.estado, bus.done); end
    press(B_START | B_MAIS);
    checks++; if (bus.estado !== 2'd3 || bus.magnetron !== 1'b0) begin errors++; $display("FAIL done_ignores got st%0d m%0b exp st3 m0", bus.estado, bus.magnetron); end
    press(B_STOP);
    checks++; if (bus.estado !== 2'd0 || bus.done !== 1'b0 || bus.sec_out !== 6'd1) begin errors++; $display("FAIL done_stop got st%0d d%0b s%0d exp st0 d0 s1", bus.estado, bus.done, bus.sec_out); end
  endtask

  task automatic test_pause_door;
    press(B_STOP);
    bus.step_mode = 2'd1;
    press(B_MAIS);
    press(B_START);
    wait_cyc(2);
    checks++; if (bus.magnetron !== 1'b1) begin errors++; $display("FAIL door_pre_mag got %0b exp 1", bus.magnetron); end
    bus.porta = 1'b1;
    #1;
    checks++; if (bus.magnetron !== 1'b0) begin errors++; $display("FAIL door_mag_now got %0b exp 0", bus.magnetron); end
    @(negedge clock);
    checks++; if (bus.estado !== 2'd2) begin errors++; $display("FAIL door_paused got %0d exp 2", bus.estado); end
    press(B_START);
    wait_cyc(6);
    checks++; if (bus.estado !== 2'd2 || bus.sec_out !== 6'd10 || bus.magnetron !== 1'b0) begin errors++; $display("FAIL paused_hold got st%0d s%0d m%0b exp st2 s10 m0", bus.estado, bus.sec_out, bus.magnetron); end
    bus.porta = 1'b0;
    press(B_START);
    checks++; if (bus.estado !== 2'd1 || bus.sec_out !== 6'd10) begin errors++; $display("FAIL resume got st%0d s%0d exp st1 s10", bus.estado, bus.sec_out); end
    wait_cyc(1);
    checks++; if (bus.sec_out !== 6'd10) begin errors++; $display("FAIL resume_presc1 got %0d exp 10", bus.sec_out); end
    wait_cyc(1);
    checks++; if (bus.sec_out !== 6'd9) begin errors++; $display("FAIL resume_presc2 got %0d exp 9", bus.sec_out); end
    press(B_PAUSE);
    checks++; if (bus.estado !== 2'd2) begin errors++; $display("FAIL pause_btn got %0d exp 2", bus.estado); end
    bus.stage_sel = 2'd1; bus.sel_pot = 1'b1;
    press(B_MENOS);
    checks++; if (bus.stage_out !== 2'd0 || bus.pot_out !== 3'd4) begin errors++; $display("FAIL locked_edit got stg%0d p%0d exp stg0 p4", bus.stage_out, bus.pot_out); end
    bus.stage_sel = 2'd0; bus.sel_pot = 1'b0;
    press(B_PAUSE);
    checks++; if (bus.estado !== 2'd1) begin errors++; $display("FAIL pause_resume got %0d exp 1", bus.estado); end
    press(B_STOP);
    checks++; if (bus.estado !== 2'd0 || bus.min_out !== 7'd0 || bus.sec_out !== 6'd10) begin errors++; $display("FAIL run_stop_retain got st%0d %0d:%0d exp st0 0:10", bus.estado, bus.min_out, bus.sec_out); end
  endtask

  task automatic test_stop_priority;
    press(B_STOP);
    bus.step_mode = 2'd0;
    repeat (3) press(B_MAIS);
    press(B_START);
    wait_cyc(2);
    press(B_STOP | B_PAUSE);
    checks++; if (bus.estado !== 2'd0 || bus.sec_out !== 6'd3 || bus.magnetron !== 1'b0) begin errors++; $display("FAIL stop_prio got st%0d s%0d m%0b exp st0 s3 m0", bus.estado, bus.sec_out, bus.magnetron); end
  endtask

  task automatic test_duty;
    press(B_STOP);
    bus.sel_pot = 1'b1;
    repeat (3) press(B_MENOS);
    checks++; if (bus.pot_out !== 3'd1) begin errors++; $display("FAIL duty_pot got %0d exp 1", bus.pot_out); end
    bus.sel_pot = 1'b0; bus.step_mode = 2'd1;
    press(B_MAIS);
    press(B_START);
    checks++; if (bus.magnetron !== 1'b1) begin errors++; $display("FAIL duty_e0 got %0b exp 1", bus.magnetron); end
    wait_cyc(7);
    checks++; if (bus.magnetron !== 1'b1) begin errors++; $display("FAIL duty_e7 got %0b exp 1", bus.magnetron); end
    wait_cyc(1);
    checks++; if (bus.magnetron !== 1'b0) begin errors++; $display("FAIL duty_e8 got %0b exp 0", bus.magnetron); end
    wait_cyc(11);
    checks++; if (bus.magnetron !== 1'b0) begin errors++; $display("FAIL duty_e19 got %0b exp 0", bus.magnetron); end
    wait_cyc(1);
    checks++; if (bus.magnetron !== 1'b1 || bus.sec_out !== 6'd5) begin errors++; $display("FAIL duty_e20 got m%0b s%0d exp m1 s5", bus.magnetron, bus.sec_out); end
  endtask

  task automatic test_async_reset;
    wait_cyc(2);
    checks++; if (bus.magnetron !== 1'b1 || bus.estado !== 2'd1) begin errors++; $display("FAIL pre_reset got m%0b st%0d exp m1 st1", bus.magnetron, bus.estado); end
    reset = 1'b1;
    #1;
    checks++; if (bus.magnetron !== 1'b0 || bus.estado !== 2'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL async_reset_ctl got m%0b st%0d d%0b exp m0 st0 d0", bus.magnetron, bus.estado, bus.done); end
    checks++; if (bus.min_out !== 7'd0 || bus.sec_out !== 6'd0 || bus.stage_out !== 2'd0) begin errors++; $display("FAIL async_reset_disp got %0d:%0d stg%0d exp 0:0 stg0", bus.min_out, bus.sec_out, bus.stage_out); end
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(1);
    checks++; if (bus.pot_out !== 3'd4 || bus.estado !== 2'd0) begin errors++; $display("FAIL post_reset got p%0d st%0d exp p4 st0", bus.pot_out, bus.estado); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_start_blocked();
    test_program_and_run();
    test_time_limits();
    test_done_stop();
    test_pause_door();
    test_stop_priority();
    test_duty();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_microondas_prog.md
CTRL_MICROONDAS_PROG -- requirements
Module: ctrl_microondas_prog

Interface
REQ-001 Parameter NUM_STAGES, default 2, number of programmable cooking stages (1..4).
REQ-002 Parameter NUM_POT, default 5, number of power levels (2..8).
REQ-003 Parameter MAX_MIN, default 99, maximum minutes per stage (1..99).
REQ-004 Parameter TICK_DIV, default 100_000_000, clock cycles per countdown second.
REQ-005 Parameter BEEP_SEC, default 3, seconds the done indication is held.
REQ-006 clock  in  1  single system clock, all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start, stop, pause, mais, menos  in  1 each  raw buttons, rising-edge detected internally.
REQ-009 porta  in  1  level, 1 = door open.
REQ-010 sel_pot  in  1  level, 1 = mais/menos adjust power, 0 = adjust time.
REQ-011 step_mode  in  2  time step: 00 = 1 s, 01 = 10 s, 10 = 1 min, 11 = 10 min.
REQ-012 stage_sel  in  2  stage being edited in IDLE; values >= NUM_STAGES ignored.
REQ-013 min_out  out  7  minutes of displayed stage; sec_out  out  6  seconds of displayed stage.
REQ-014 stage_out  out  2  displayed stage (edited stage in IDLE, active stage otherwise).
REQ-015 pot_out  out  3  power level of displayed stage.
REQ-016 estado  out  2  current state encoding.
REQ-017 magnetron  out  1  heater enable; done  out  1  high throughout DONE.

Function
REQ-018 Buttons SHALL be rising-edge detected, one-cycle pulse, one cycle latency.
REQ-019 States SHALL be IDLE=00, RUN=01, PAUSED=10, DONE=11.
REQ-020 In IDLE, mais/menos with sel_pot=0 SHALL add/subtract the step_mode amount to the edited stage time, with seconds carry/borrow across minutes, saturating at 0:00 and MAX_MIN:59.
REQ-021 In IDLE, mais/menos with sel_pot=1 SHALL change the edited stage power by 1, saturating at 0 and NUM_POT-1.
REQ-022 mais and menos pulses in the same cycle SHALL leave the setting unchanged.
REQ-023 IDLE->RUN on start pulse when porta=0 and any stage time is nonzero; active stage = first nonzero stage; working copy loaded from program.
REQ-024 RUN SHALL decrement the working copy by 1 s every TICK_DIV cycles; a stage reaching 0:00 SHALL advance in the same cycle to the next nonzero stage, or to DONE if none.
REQ-025 RUN->PAUSED on pause pulse or porta=1; prescaler and working copy SHALL hold in PAUSED.
REQ-026 PAUSED->RUN on start or pause pulse with porta=0.
REQ-027 RUN or PAUSED ->IDLE on stop pulse; stop SHALL take priority over every other event in the same cycle.
REQ-028 stop pulse in IDLE SHALL clear all stage times to 0:00 and powers to NUM_POT-1.
REQ-029 DONE SHALL last BEEP_SEC seconds then return to IDLE; start/mais/menos ignored in DONE; stop exits immediately.
REQ-030 The programmed stages SHALL be retained after DONE and after stop from RUN/PAUSED.
REQ-031 magnetron SHALL be 1 only in RUN, for the first pot+1 seconds of each NUM_POT-second window counted from RUN entry; 0 in all other states and immediately when porta=1.
REQ-032 Changes to step_mode, sel_pot, stage_sel outside IDLE SHALL have no effect.

Reset
REQ-033 On reset: state IDLE, all stage times 0:00, all powers NUM_POT-1, prescaler and duty counter 0, magnetron=0, done=0, stage_out=0, min_out=0, sec_out=0.
REQ-034 Reset mid-RUN SHALL drop magnetron in the same instant, asynchronously.

Structure
REQ-035 State encodings and step_mode encodings SHALL live in shared package microondas_pkg.
REQ-036 Edge detection SHALL reuse existing sub-module edge_detector, one instance per button.

Verification (TICK_DIV=4, NUM_POT=5, NUM_STAGES=2)
REQ-037 Stage0 set 0:03 pot 4, stage1 0:02 pot 0, start -> RUN, stage_out 0 for 12 cycles, then stage 1, DONE after 8 more cycles, done high 12 cycles, IDLE.
REQ-038 Stage0 at 99:55, step 01 mais -> 99:59; at 0:05 step 01 menos -> 0:00.
REQ-039 RUN at 0:10, porta=1 -> PAUSED, magnetron 0 same cycle; porta=0 plus start -> resumes 0:10 count without loss.
REQ-040 stop and pause pulses in the same RUN cycle -> IDLE, program restored to 0:03.
REQ-041 Stage0 pot 1, time 0:10 -> magnetron high 2 s, low 3 s, repeating.
REQ-042 Assert reset mid-RUN -> all outputs at reset values before next clock edge.
